// File: rtl/icache_refill_unit_if.sv
// rtl/icache_refill_unit_if.sv - cache-side and memory-side handshake bundle for the icache refill unit
interface icache_refill_unit_if #(
  parameter int ADDRWIDTH = 32,
  parameter int DATAWIDTH = 32
);
  logic                 miss;
  logic [ADDRWIDTH-1:0] fetchaddr;
  logic [DATAWIDTH-1:0] ifetch;
  logic                 iready;
  logic                 mem_req;
  logic [ADDRWIDTH-1:0] mem_addr;
  logic                 mem_gnt;
  logic                 mem_rvalid;
  logic [DATAWIDTH-1:0] mem_rdata;

  modport master (
    input  miss, fetchaddr, mem_gnt, mem_rvalid, mem_rdata,
    output ifetch, iready, mem_req, mem_addr
  );

  modport slave (
    output miss, fetchaddr, mem_gnt, mem_rvalid, mem_rdata,
    input  ifetch, iready, mem_req, mem_addr
  );
endinterface

// File: rtl/icache_refill_unit.sv
// rtl/icache_refill_unit.sv - single-word icache miss refill with timeout, sticky error and refill counter
module icache_refill_unit #(
  parameter int                   ADDRWIDTH  = 32,
  parameter int                   DATAWIDTH  = 32,
  parameter int                   BLOCKSIZE  = 4,
  parameter int                   TIMEOUT    = 255,
  parameter logic [DATAWIDTH-1:0] NOPINSTR   = 32'h00000013,
  parameter int                   COUNTWIDTH = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  icache_refill_unit_if.master  bus,
  output logic                  busy,
  output logic                  refill_error,
  output logic [COUNTWIDTH-1:0] refill_count
);
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [ADDRWIDTH-1:0] ALIGN_MASK = ~ADDRWIDTH'(BLOCKSIZE - 1);

  typedef enum logic [2:0] {IDLE, REQ, WAIT, RESP, HOLD} state_t;

  state_t               state, state_nxt;
  logic [ADDRWIDTH-1:0] addr_q;
  logic [DATAWIDTH-1:0] ifetch_q;
  logic [TW-1:0]        tmo_cnt;
  logic                 accept;
  logic                 expire;

  always_ff @(posedge clk) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  // Data arriving on the last allowed cycle wins over the timeout abort.
  always_comb begin
    accept    = 1'b0;
    expire    = 1'b0;
    state_nxt = state;
    if (state == REQ)  accept = bus.mem_gnt && bus.mem_rvalid;
    if (state == WAIT) accept = bus.mem_rvalid;
    if ((state == REQ || state == WAIT) && tmo_cnt == TW'(TIMEOUT - 1) && !accept)
      expire = 1'b1;
    case (state)
      IDLE: if (bus.miss) state_nxt = REQ;
      REQ: begin
        if (accept || expire) state_nxt = RESP;
        else if (bus.mem_gnt) state_nxt = WAIT;
      end
      WAIT: if (accept || expire) state_nxt = RESP;
      RESP: state_nxt = HOLD;
      HOLD: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      addr_q       <= '0;
      ifetch_q     <= '0;
      tmo_cnt      <= '0;
      refill_error <= 1'b0;
      refill_count <= '0;
    end else begin
      if (state == IDLE && bus.miss) begin
        addr_q       <= bus.fetchaddr & ALIGN_MASK;
        tmo_cnt      <= '0;
        refill_error <= 1'b0;
      end
      if (state == REQ || state == WAIT) tmo_cnt <= tmo_cnt + TW'(1);
      if (accept) begin
        ifetch_q <= bus.mem_rdata;
        if (refill_count != '1) refill_count <= refill_count + COUNTWIDTH'(1);
      end
      if (expire) begin
        ifetch_q     <= NOPINSTR;
        refill_error <= 1'b1;
      end
    end
  end

  assign bus.mem_req  = (state == REQ);
  assign bus.mem_addr = addr_q;
  assign bus.ifetch   = ifetch_q;
  assign bus.iready   = (state == RESP);
  assign busy         = (state != IDLE);
endmodule
